// File: rtl/cc_bus_rr_arbiter_if.sv
// Bus bundle for the round-robin channel merger.
// CC_BUS_PACKET_LOCK_EN adds the per-beat last flags.
interface cc_bus_rr_arbiter_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int CHANNELS      = 4,
  parameter int CHSEL_W       = 2
);
  logic [CHANNELS*DATAWIDTH_BUS-1:0] CC_BUS_DataBUS_In;
  logic [CHANNELS-1:0]               CC_BUS_Valid_In;
  logic [CHANNELS-1:0]               CC_BUS_Ready_Out;
  logic [DATAWIDTH_BUS-1:0]          CC_BUS_DataBUS_Out;
  logic                              CC_BUS_Valid_Out;
  logic                              CC_BUS_Ready_In;
  logic [CHSEL_W-1:0]                CC_BUS_Grant_Out;
`ifdef CC_BUS_PACKET_LOCK_EN
  logic [CHANNELS-1:0]               CC_BUS_Last_In;
  logic                              CC_BUS_Last_Out;
`endif

  modport slave (
    input  CC_BUS_DataBUS_In,
    input  CC_BUS_Valid_In,
    output CC_BUS_Ready_Out,
    output CC_BUS_DataBUS_Out,
    output CC_BUS_Valid_Out,
    input  CC_BUS_Ready_In,
`ifdef CC_BUS_PACKET_LOCK_EN
    input  CC_BUS_Last_In,
    output CC_BUS_Last_Out,
`endif
    output CC_BUS_Grant_Out
  );

  modport master (
    output CC_BUS_DataBUS_In,
    output CC_BUS_Valid_In,
    input  CC_BUS_Ready_Out,
    input  CC_BUS_DataBUS_Out,
    input  CC_BUS_Valid_Out,
    output CC_BUS_Ready_In,
`ifdef CC_BUS_PACKET_LOCK_EN
    output CC_BUS_Last_In,
    input  CC_BUS_Last_Out,
`endif
    input  CC_BUS_Grant_Out
  );
endinterface

// File: rtl/cc_bus_rr_arbiter.sv
// Round-robin merge of CHANNELS source buses into a 2-entry output FIFO.
// CC_BUS_PACKET_LOCK_EN: hold the grant on one channel until a last beat.
module cc_bus_rr_arbiter #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int CHANNELS      = 4,
  parameter int CHSEL_W       = 2
) (
  input  logic             CC_BUS_CLOCK_50,
  input  logic             CC_BUS_RESET_InHigh,
  cc_bus_rr_arbiter_if.slave bus
);

  typedef struct packed {
    logic [CHSEL_W-1:0]       g;
    logic [DATAWIDTH_BUS-1:0] d;
`ifdef CC_BUS_PACKET_LOCK_EN
    logic                     l;
`endif
  } ent_t;

  logic [1:0]          cnt_q, cnt_d;
  logic [CHSEL_W-1:0]  ptr_q, ptr_d;
  ent_t                e0_q, e0_d;
  ent_t                e1_q, e1_d;
  ent_t                nw;
  logic [CHANNELS-1:0] rdy;
  logic [CHSEL_W-1:0]  win;
  logic [CHSEL_W-1:0]  idx;
  logic                found;
  logic                push;
  logic                pop;
`ifdef CC_BUS_PACKET_LOCK_EN
  logic                lock_q, lock_d;
  logic [CHSEL_W-1:0]  lch_q, lch_d;
`endif

  always_comb begin
    rdy   = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = CHSEL_W'((int'(ptr_q) + k) % CHANNELS);
      if (!found && bus.CC_BUS_Valid_In[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef CC_BUS_PACKET_LOCK_EN
    if (lock_q) begin
      found = bus.CC_BUS_Valid_In[lch_q];
      win   = lch_q;
    end
`endif
    if (found && cnt_q != 2'd2 && !CC_BUS_RESET_InHigh)
      rdy[win] = 1'b1;
  end

  assign push = |rdy;
  assign pop  = (cnt_q != 2'd0) & bus.CC_BUS_Ready_In;

  always_comb begin
    nw   = '0;
    nw.g = win;
    nw.d = bus.CC_BUS_DataBUS_In[int'(win)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
`ifdef CC_BUS_PACKET_LOCK_EN
    nw.l = bus.CC_BUS_Last_In[win];
`endif
  end

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop)
      e0_d = e1_q;
    if (push) begin
      ptr_d = win;
      // slot after the pop-shift: head if it ends up empty, else second
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))
        e0_d = nw;
      else
        e1_d = nw;
    end
  end

`ifdef CC_BUS_PACKET_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    lch_d  = lch_q;
    if (push) begin
      lock_d = !nw.l;
      lch_d  = win;
    end
  end
`endif

  always_ff @(posedge CC_BUS_CLOCK_50) begin
    if (CC_BUS_RESET_InHigh) begin
      cnt_q  <= '0;
      ptr_q  <= CHSEL_W'(CHANNELS - 1);
      e0_q   <= '0;
      e1_q   <= '0;
`ifdef CC_BUS_PACKET_LOCK_EN
      lock_q <= 1'b0;
      lch_q  <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      e0_q   <= e0_d;
      e1_q   <= e1_d;
`ifdef CC_BUS_PACKET_LOCK_EN
      lock_q <= lock_d;
      lch_q  <= lch_d;
`endif
    end
  end

  assign bus.CC_BUS_Ready_Out   = rdy;
  assign bus.CC_BUS_Valid_Out   = cnt_q != 2'd0;
  assign bus.CC_BUS_DataBUS_Out = e0_q.d;
  assign bus.CC_BUS_Grant_Out   = e0_q.g;
`ifdef CC_BUS_PACKET_LOCK_EN
  assign bus.CC_BUS_Last_Out    = e0_q.l;
`endif

endmodule

// File: tb/tb_cc_bus_rr_arbiter.sv
// Directed bench for cc_bus_rr_arbiter.
// Lock checks build only with CC_BUS_PACKET_LOCK_EN.
module tb_cc_bus_rr_arbiter;
  localparam int DW = 32;
  localparam int CH = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cc_bus_rr_arbiter_if #(
    .DATAWIDTH_BUS(DW),
    .CHANNELS(CH),
    .CHSEL_W(SW)
  ) bus ();

  cc_bus_rr_arbiter #(
    .DATAWIDTH_BUS(DW),
    .CHANNELS(CH),
    .CHSEL_W(SW)
  ) dut (
    .CC_BUS_CLOCK_50(clk),
    .CC_BUS_RESET_InHigh(rst),
    .bus(bus)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    bus.CC_BUS_DataBUS_In[ch*DW +: DW] = v;
  endtask

  task automatic out_chk(input string tag, input logic vo,
                         input logic [SW-1:0] g,
                         input logic [DW-1:0] d);
    check({tag, "_vld"}, 64'(bus.CC_BUS_Valid_Out), 64'(vo));
    check({tag, "_gnt"}, 64'(bus.CC_BUS_Grant_Out), 64'(g));
    check({tag, "_dat"}, 64'(bus.CC_BUS_DataBUS_Out), 64'(d));
  endtask

  initial begin
    bus.CC_BUS_DataBUS_In = '0;
    bus.CC_BUS_Valid_In   = '0;
    bus.CC_BUS_Ready_In   = 1'b0;
`ifdef CC_BUS_PACKET_LOCK_EN
    bus.CC_BUS_Last_In    = '0;
`endif
    for (int i = 0; i < CH; i++)
      set_data(i, 32'hA000_0000 | 32'(i));

    // reset state
    for (int i = 0; i < 3; i++) tick();
    out_chk("rst", 1'b0, 2'd0, 32'h0);
    check("rst_rdy", 64'(bus.CC_BUS_Ready_Out), 64'h0);

    // all channels valid, full throughput rotation
    rst = 1'b0;
    bus.CC_BUS_Valid_In = 4'b1111;
    bus.CC_BUS_Ready_In = 1'b1;
    #1;
    check("rr_rdy0", 64'(bus.CC_BUS_Ready_Out), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      out_chk($sformatf("rr%0d", k), 1'b1, 2'(k % 4),
              32'hA000_0000 | 32'(k % 4));
      check($sformatf("rr_rdy%0d", k + 1),
            64'(bus.CC_BUS_Ready_Out), 64'(4'b0001 << ((k + 1) % 4)));
    end
    bus.CC_BUS_Valid_In = 4'b0000;
    tick();
    check("rr_drain", 64'(bus.CC_BUS_Valid_Out), 64'h0);

    // backpressure: only ch2, buffer fills to two
    bus.CC_BUS_Ready_In = 1'b0;
    bus.CC_BUS_Valid_In = 4'b0100;
    set_data(2, 32'hC000_0001);
    #1;
    check("bp_rdy_a", 64'(bus.CC_BUS_Ready_Out), 64'b0100);
    tick();
    out_chk("bp_w1", 1'b1, 2'd2, 32'hC000_0001);
    set_data(2, 32'hC000_0002);
    #1;
    check("bp_rdy_b", 64'(bus.CC_BUS_Ready_Out), 64'b0100);
    tick();
    check("bp_full_rdy", 64'(bus.CC_BUS_Ready_Out), 64'h0);
    set_data(2, 32'hC000_0003);
    tick();
    tick();
    out_chk("bp_hold", 1'b1, 2'd2, 32'hC000_0001);
    check("bp_hold_rdy", 64'(bus.CC_BUS_Ready_Out), 64'h0);
    bus.CC_BUS_Valid_In = 4'b0000;
    bus.CC_BUS_Ready_In = 1'b1;
    tick();
    out_chk("bp_w2", 1'b1, 2'd2, 32'hC000_0002);
    tick();
    check("bp_empty", 64'(bus.CC_BUS_Valid_Out), 64'h0);

    // wrap: ch3 wins, then ch0 ahead of ch3
    set_data(3, 32'hD000_0003);
    set_data(0, 32'hD000_0000);
    bus.CC_BUS_Valid_In = 4'b1000;
    #1;
    check("wr_rdy3", 64'(bus.CC_BUS_Ready_Out), 64'b1000);
    tick();
    out_chk("wr_g3", 1'b1, 2'd3, 32'hD000_0003);
    bus.CC_BUS_Valid_In = 4'b1001;
    set_data(3, 32'hD000_0033);
    #1;
    check("wr_rdy0", 64'(bus.CC_BUS_Ready_Out), 64'b0001);
    tick();
    out_chk("wr_g0", 1'b1, 2'd0, 32'hD000_0000);
    bus.CC_BUS_Valid_In = 4'b1000;
    #1;
    check("wr_rdy3b", 64'(bus.CC_BUS_Ready_Out), 64'b1000);
    tick();
    out_chk("wr_g3b", 1'b1, 2'd3, 32'hD000_0033);
    bus.CC_BUS_Valid_In = 4'b0000;
    tick();
    check("wr_empty", 64'(bus.CC_BUS_Valid_Out), 64'h0);

    // reset with a full buffer
    bus.CC_BUS_Ready_In = 1'b0;
    bus.CC_BUS_Valid_In = 4'b0101;
    set_data(0, 32'hE000_0000);
    set_data(2, 32'hE000_0002);
    tick();
    tick();
    check("mr_full_rdy", 64'(bus.CC_BUS_Ready_Out), 64'h0);
    out_chk("mr_full", 1'b1, 2'd0, 32'hE000_0000);
    rst = 1'b1;
    #1;
    check("mr_rst_rdy", 64'(bus.CC_BUS_Ready_Out), 64'h0);
    tick();
    out_chk("mr_rst", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    bus.CC_BUS_Ready_In = 1'b1;
    #1;
    check("mr_rdy0", 64'(bus.CC_BUS_Ready_Out), 64'b0001);
    tick();
    out_chk("mr_g0", 1'b1, 2'd0, 32'hE000_0000);
    bus.CC_BUS_Valid_In = 4'b0000;
    tick();
    check("mr_empty", 64'(bus.CC_BUS_Valid_Out), 64'h0);

`ifdef CC_BUS_PACKET_LOCK_EN
    // pointer now 0: ch1 wins first and holds the grant for 3 beats
    bus.CC_BUS_Valid_In = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      set_data(1, 32'hF000_0010 | 32'(b));
      bus.CC_BUS_Last_In = (b == 2) ? 4'b0010 : 4'b0000;
      #1;
      check($sformatf("pk_rdy%0d", b),
            64'(bus.CC_BUS_Ready_Out), 64'b0010);
      tick();
      out_chk($sformatf("pk%0d", b), 1'b1, 2'd1,
              32'hF000_0010 | 32'(b));
      check($sformatf("pk_last%0d", b),
            64'(bus.CC_BUS_Last_Out), 64'(b == 2));
    end
    bus.CC_BUS_Last_In  = 4'b0000;
    bus.CC_BUS_Valid_In = 4'b0101;
    set_data(2, 32'hF000_0002);
    #1;
    check("pk_rdy2", 64'(bus.CC_BUS_Ready_Out), 64'b0100);
    tick();
    out_chk("pk_g2", 1'b1, 2'd2, 32'hF000_0002);
    check("pk_last_g2", 64'(bus.CC_BUS_Last_Out), 64'h0);
    bus.CC_BUS_Valid_In = 4'b0000;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
